// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: diff = a - b, LSB first, one bit per clock.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       state_dbg
);

    // Handshake: operands transfer on a rising edge where start_valid && start_ready;
    // start_ready is high only in IDLE, so start_valid is ignored while busy.

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             d_bit;
    logic             bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        d_bit = a_sh_q[0] ^ b_sh_q[0] ^ bin_q;
        bout  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bin_q);

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    res_d   = '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                bin_d  = bout;
                // The counter holds at the last bit rather than wrapping.
                if (cnt_q == LAST) begin
                    diff_d   = res_d;
                    borrow_d = bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign diff        = diff_q;
    assign borrow      = borrow_q;
    assign state_dbg   = state_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Bench for serial_subtractor_nbit: WIDTH=8 instance checked every cycle against a
// timeline model, WIDTH=2 instance swept exhaustively through a scoreboard queue.
module tb_serial_subtractor_nbit;
  localparam int W8 = 8;
  localparam int W2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          sv8 = 1'b0, rdy8, busy8, done8, bor8, ovf8;
  logic [W8-1:0] a8 = '0, b8 = '0, diff8;
  logic [1:0]    st8;
  logic          sv2 = 1'b0, rdy2, busy2, done2, bor2, ovf2;
  logic [W2-1:0] a2 = '0, b2 = '0, diff2;
  logic [1:0]    st2;

  serial_subtractor_nbit #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(rdy8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .diff(diff8), .borrow(bor8),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    .ovf(ovf8),
`endif
    .state_dbg(st8)
  );

  serial_subtractor_nbit #(.WIDTH(W2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(rdy2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .diff(diff2), .borrow(bor2),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    .ovf(ovf2),
`endif
    .state_dbg(st2)
  );

`ifndef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf2 = 1'b0;
`endif

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed_ovf8(input logic [W8-1:0] x, input logic [W8-1:0] y);
    int s;
    s = int'($signed(x)) - int'($signed(y));
    return (s > 127) || (s < -128);
  endfunction

  // ---------------- behavioural model for the WIDTH=8 instance ----------------
  // m_since: -1 when idle, otherwise edges elapsed since the accept edge.
  int          cyc = 0;
  int          m_since = -1;
  logic [W8-1:0] m_pa = '0, m_pb = '0, m_diff = '0;
  logic        m_bor = 1'b0, m_ovf = 1'b0;
  int          acc8_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_since <= -1;
      m_diff  <= '0;
      m_bor   <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_since < 0) begin
      if (sv8) begin
        m_since <= 0;
        m_pa    <= a8;
        m_pb    <= b8;
        acc8_q.push_back(cyc);
      end
    end else if (m_since == W8) begin
      m_since <= -1;
    end else begin
      m_since <= m_since + 1;
      if (m_since == W8 - 1) begin
        m_diff <= m_pa - m_pb;
        m_bor  <= (m_pa < m_pb);
        m_ovf  <= signed_ovf8(m_pa, m_pb);
      end
    end
  end

  // ---------------- scoreboard for the WIDTH=2 instance ----------------
  logic [W2:0] exp2_q[$];
  int done8_cnt = 0;
  int done2_cnt = 0;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("start_ready8", rdy8, m_since < 0);
    check("busy8", busy8, m_since >= 0);
    check("done8", done8, m_since == W8);
    check("diff8", diff8, m_diff);
    check("borrow8", bor8, m_bor);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check("ovf8", ovf8, m_ovf);
`endif
    if (done8) done8_cnt++;
    if (done2) begin
      done2_cnt++;
      if (exp2_q.size() == 0) begin
        check("sb2_unexpected_done", 1, 0);
      end else begin
        check("sb2_result", {bor2, diff2}, exp2_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready8();
    int n = 0;
    while (!rdy8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready8_wait", rdy8, 1);
  endtask

  task automatic op8(input logic [W8-1:0] x, input logic [W8-1:0] y, input logic [W8-1:0] ed,
                     input logic eb, input logic eo, input string name);
    int n;
    wait_ready8();
    sv8 = 1'b1; a8 = x; b8 = y;
    @(negedge clk);
    sv8 = 1'b0; a8 = W8'($urandom); b8 = W8'($urandom);
    check({name, "_ready_drop"}, rdy8, 0);
    n = 1;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n - 1, W8);
    check({name, "_diff"}, diff8, ed);
    check({name, "_borrow"}, bor8, eb);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check({name, "_ovf"}, ovf8, eo);
`else
    if (eo) n = 0;
`endif
  endtask

  task automatic op2(input logic [W2-1:0] x, input logic [W2-1:0] y);
    int n = 0;
    while (!rdy2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready2_wait", rdy2, 1);
    sv2 = 1'b1; a2 = x; b2 = y;
    exp2_q.push_back({x < y, W2'(x - y)});
    @(negedge clk);
    sv2 = 1'b0;
    n = 1;
    while (!done2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency2", n - 1, W2);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [W8-1:0] res_d[2];
    logic          res_b[2];
    int            got, base, n;

    repeat (3) @(negedge clk);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_diff", diff8, 0);
    check("reset_borrow", bor8, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", rdy8, 1);

    op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "t_05_03");
    op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "t_03_05");
    op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "t_80_01");
    op8(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "t_00_FF");
    op8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "t_00_00");

    // start_valid held high across an operation in flight
    wait_ready8();
    base = done8_cnt;
    sv8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55;
    got = 0; n = 0;
    while (got < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (done8) begin
        res_d[got] = diff8;
        res_b[got] = bor8;
        got++;
      end
    end
    sv8 = 1'b0;
    check("hold_done_count", got, 2);
    check("hold_first_diff", res_d[0], 8'h0F);
    check("hold_first_borrow", res_b[0], 0);
    check("hold_second_diff", res_d[1], 8'h55);
    check("hold_second_borrow", res_b[1], 0);
    check("hold_accept_gap", acc8_q[acc8_q.size()-1] - acc8_q[acc8_q.size()-2], W8 + 2);
    repeat (2) @(negedge clk);
    check("hold_done_pulses", done8_cnt - base, 2);

    // reset in the middle of an operation
    wait_ready8();
    base = done8_cnt;
    sv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
    @(negedge clk);
    sv8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_diff", diff8, 0);
    check("abort_borrow", bor8, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (W8 + 2) @(negedge clk);
    check("abort_no_done", done8_cnt - base, 0);
    op8(8'h09, 8'h09, 8'h00, 1'b0, 1'b0, "t_09_09");

    // randomized traffic, valid may toggle while busy
    for (int i = 0; i < 600; i++) begin
      sv8 = 1'($urandom_range(0, 1));
      a8  = W8'($urandom);
      b8  = W8'($urandom);
      @(negedge clk);
    end
    sv8 = 1'b0;

    // exhaustive WIDTH=2 sweep
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        op2(W2'(i), W2'(j));
    repeat (4) @(negedge clk);
    check("sb2_drained", exp2_q.size(), 0);
    check("sb2_done_count", done2_cnt, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
